// File: rtl/speed_pkg.sv
// Shared definitions for the speed-round push counter: FSM encodings and
// the default counter width.
package speed_pkg;

  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_COUNTING = 2'b01;
  localparam logic [1:0] ST_DONE     = 2'b10;

  typedef struct packed {
    logic right;
    logic tie;
  } speed_result_t;

endpackage

// File: rtl/push_edge_detect.sv
// Brings one asynchronous debounced button into the clock domain and emits a
// single-cycle pulse for each press.
module push_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic push_o
);

  logic sync1_q, sync2_q, hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign push_o = sync2_q & ~hist_q;

endmodule

// File: rtl/speed_push_counter.sv
// Speed-round push counter: counts left/right button presses inside the
// counting window and latches the winner when the round controller closes it.
module speed_push_counter
  import speed_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TIE_MARGIN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             speed_round,
  input  logic             winspeed,
  input  logic             pb_left,
  input  logic             pb_right,
  output logic             speed_right,
  output logic             speed_tie,
  output logic             result_valid,
  output logic             counting,
  output logic [CNT_W-1:0] left_count,
  output logic [CNT_W-1:0] right_count
);

  localparam logic [CNT_W:0] MARGIN = (CNT_W+1)'(TIE_MARGIN);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic [CNT_W-1:0] right_q, right_d;
  speed_result_t    res_q, res_d;
  logic             valid_q, valid_d;

  logic push_l, push_r;

  logic [CNT_W:0] l_ext, r_ext, diff;
  speed_result_t  res_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  push_edge_detect u_edge_left (
    .clk_i  (clk),
    .rst_ni (rst),
    .pin_i  (pb_left),
    .push_o (push_l)
  );

  push_edge_detect u_edge_right (
    .clk_i  (clk),
    .rst_ni (rst),
    .pin_i  (pb_right),
    .push_o (push_r)
  );

  // Compare is done one bit wider so the margin add cannot wrap for sane margins
  always_comb begin
    l_ext         = {1'b0, left_q};
    r_ext         = {1'b0, right_q};
    diff          = (r_ext >= l_ext) ? (r_ext - l_ext) : (l_ext - r_ext);
    res_now.right = (r_ext > (l_ext + MARGIN));
    res_now.tie   = (diff <= MARGIN);
  end

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    right_d = right_q;
    res_d   = res_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (speed_round) begin
          state_d = ST_COUNTING;
          left_d  = '0;
          right_d = '0;
          res_d   = '0;
          valid_d = 1'b0;
        end
      end
      ST_COUNTING: begin
        // A press landing on the closing cycle is dropped; the compare sees pre-edge counts
        if (winspeed) begin
          state_d = ST_DONE;
          res_d   = res_now;
          valid_d = 1'b1;
        end else begin
          if (push_l) left_d  = sat_inc(left_q);
          if (push_r) right_d = sat_inc(right_q);
        end
      end
      ST_DONE: begin
        if (speed_round) begin
          state_d = ST_COUNTING;
          left_d  = '0;
          right_d = '0;
          res_d   = '0;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        left_d  = '0;
        right_d = '0;
        res_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      left_q  <= '0;
      right_q <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      right_q <= right_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign speed_right  = res_q.right;
  assign speed_tie    = res_q.tie;
  assign result_valid = valid_q;
  assign counting     = (state_q == ST_COUNTING);
  assign left_count   = left_q;
  assign right_count  = right_q;

endmodule

// File: tb/tb_speed_push_counter.sv
// Bench for speed_push_counter: three configurations share one stimulus
// stream and are compared every cycle against a behavioural round model.
module tb_speed_push_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic speed_round = 1'b0;
  logic winspeed = 1'b0;
  logic pb_left = 1'b0;
  logic pb_right = 1'b0;

  always #5 clk = ~clk;

  logic       sr0, tie0, v0, c0;
  logic [7:0] lc0, rc0;
  logic       sr1, tie1, v1, c1;
  logic [2:0] lc1, rc1;
  logic       sr2, tie2, v2, c2;
  logic [7:0] lc2, rc2;

  speed_push_counter dut0 (
    .clk(clk), .rst(rst), .speed_round(speed_round), .winspeed(winspeed),
    .pb_left(pb_left), .pb_right(pb_right), .speed_right(sr0), .speed_tie(tie0),
    .result_valid(v0), .counting(c0), .left_count(lc0), .right_count(rc0));

  speed_push_counter #(.CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .speed_round(speed_round), .winspeed(winspeed),
    .pb_left(pb_left), .pb_right(pb_right), .speed_right(sr1), .speed_tie(tie1),
    .result_valid(v1), .counting(c1), .left_count(lc1), .right_count(rc1));

  speed_push_counter #(.TIE_MARGIN(1)) dut2 (
    .clk(clk), .rst(rst), .speed_round(speed_round), .winspeed(winspeed),
    .pb_left(pb_left), .pb_right(pb_right), .speed_right(sr2), .speed_tie(tie2),
    .result_valid(v2), .counting(c2), .left_count(lc2), .right_count(rc2));

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: a round is idle / open / decided; presses are pin
  // rising transitions seen two clocks late through the synchronizer.
  function automatic int maxv(input int i);
    return (i == 1) ? 7 : 255;
  endfunction

  function automatic int mar(input int i);
    return (i == 2) ? 1 : 0;
  endfunction

  int   st;
  int   mL[3];
  int   mR[3];
  logic mSR[3];
  logic mTie[3];
  logic mv;
  logic [2:0] phl, phr;

  wire pushL = phl[1] & ~phl[2];
  wire pushR = phr[1] & ~phr[2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= 0;
      mv <= 1'b0;
      phl <= '0;
      phr <= '0;
      for (int i = 0; i < 3; i++) begin
        mL[i] <= 0; mR[i] <= 0; mSR[i] <= 1'b0; mTie[i] <= 1'b0;
      end
    end else begin
      phl <= {phl[1:0], pb_left};
      phr <= {phr[1:0], pb_right};
      if ((st == 0 || st == 2) && speed_round) begin
        st <= 1;
        mv <= 1'b0;
        for (int i = 0; i < 3; i++) begin
          mL[i] <= 0; mR[i] <= 0; mSR[i] <= 1'b0; mTie[i] <= 1'b0;
        end
      end else if (st == 1 && winspeed) begin
        st <= 2;
        mv <= 1'b1;
        for (int i = 0; i < 3; i++) begin
          mSR[i]  <= (mR[i] > mL[i] + mar(i));
          mTie[i] <= (((mR[i] > mL[i]) ? mR[i] - mL[i] : mL[i] - mR[i]) <= mar(i));
        end
      end else if (st == 1) begin
        for (int i = 0; i < 3; i++) begin
          if (pushL) mL[i] <= (mL[i] + 1 > maxv(i)) ? maxv(i) : mL[i] + 1;
          if (pushR) mR[i] <= (mR[i] + 1 > maxv(i)) ? maxv(i) : mR[i] + 1;
        end
      end
    end
  end

  task automatic chk_inst(input int i, input logic [31:0] lc, input logic [31:0] rc,
                          input logic sr, input logic tie, input logic v, input logic c);
    chk($sformatf("d%0d_left_count", i), lc, mL[i]);
    chk($sformatf("d%0d_right_count", i), rc, mR[i]);
    chk($sformatf("d%0d_speed_right", i), {31'b0, sr}, {31'b0, mSR[i]});
    chk($sformatf("d%0d_speed_tie", i), {31'b0, tie}, {31'b0, mTie[i]});
    chk($sformatf("d%0d_result_valid", i), {31'b0, v}, {31'b0, mv});
    chk($sformatf("d%0d_counting", i), {31'b0, c}, (st == 1) ? 32'd1 : 32'd0);
    chk($sformatf("d%0d_exclusive", i), {31'b0, sr & tie}, 32'd0);
  endtask

  task automatic compare_all();
    chk_inst(0, {24'b0, lc0}, {24'b0, rc0}, sr0, tie0, v0, c0);
    chk_inst(1, {29'b0, lc1}, {29'b0, rc1}, sr1, tie1, v1, c1);
    chk_inst(2, {24'b0, lc2}, {24'b0, rc2}, sr2, tie2, v2, c2);
  endtask

  task automatic cyc(input logic s, input logic w, input logic l, input logic r);
    @(negedge clk);
    speed_round = s; winspeed = w; pb_left = l; pb_right = r;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic press(input logic l, input logic r);
    cyc(0, 0, l, r);
    cyc(0, 0, l, r);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic presses(input int nl, input int nr);
    for (int i = 0; i < ((nl > nr) ? nl : nr); i++) press(i < nl, i < nr);
  endtask

  task automatic start();
    cyc(1, 0, 0, 0);
  endtask

  task automatic finish_round();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    logic pl, pr;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("reset_left", {24'b0, lc0}, 0);
    chk("reset_valid", {31'b0, v0}, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, 0, 0);

    presses(5, 5);
    chk("idle_left", {24'b0, lc0}, 0);
    chk("idle_right", {24'b0, rc0}, 0);

    start();
    presses(3, 5);
    chk("r1_left", {24'b0, lc0}, 3);
    chk("r1_right", {24'b0, rc0}, 5);
    finish_round();
    chk("r1_speed_right", {31'b0, sr0}, 1);
    chk("r1_tie", {31'b0, tie0}, 0);
    chk("r1_valid", {31'b0, v0}, 1);
    presses(2, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    finish_round();
    chk("hold_speed_right", {31'b0, sr0}, 1);
    chk("hold_left", {24'b0, lc0}, 3);

    start();
    chk("restart_valid", {31'b0, v0}, 0);
    chk("restart_speed_right", {31'b0, sr0}, 0);
    chk("restart_right", {24'b0, rc0}, 0);
    chk("restart_counting", {31'b0, c0}, 1);
    for (int i = 0; i < 3; i++) begin press(1, 0); press(0, 1); end
    press(1, 1);
    finish_round();
    chk("tie_tie", {31'b0, tie0}, 1);
    chk("tie_right", {31'b0, sr0}, 0);

    start();
    presses(6, 7);
    finish_round();
    chk("m1_67_tie", {31'b0, tie2}, 1);
    chk("m1_67_right", {31'b0, sr2}, 0);
    start();
    presses(6, 8);
    finish_round();
    chk("m1_68_right", {31'b0, sr2}, 1);
    chk("m1_68_tie", {31'b0, tie2}, 0);

    start();
    presses(0, 10);
    chk("sat_right_w3", {29'b0, rc1}, 7);
    chk("nosat_right_w8", {24'b0, rc0}, 10);
    finish_round();

    start();
    presses(2, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);
    chk("coinc_left", {24'b0, lc0}, 2);
    chk("coinc_valid", {31'b0, v0}, 1);

    start();
    presses(3, 2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_left", {24'b0, lc0}, 0);
    chk("midrst_counting", {31'b0, c0}, 0);
    compare_all();
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 1, 0, 0);
    chk("midrst_no_result", {31'b0, v0}, 0);

    pl = 1'b0; pr = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) pl = ~pl;
      if ($urandom_range(0, 2) == 0) pr = ~pr;
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0, pl, pr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
